// File: rtl/register_file.sv
// 32-entry x N-bit register file: one synchronous write port, two combinational
// read ports built on mux32 word selectors, x0 hardwired to zero, optional bypass.

module mux32 #(
    parameter int N = 32
) (
    input  logic [31:0][N-1:0] i_in,
    input  logic [4:0]         i_sel,
    output logic [N-1:0]       o_out
);

    assign o_out = i_in[i_sel];

endmodule

module register_file #(
    parameter int N      = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);

    logic [N-1:0]       r_regs [1:31];
    logic [31:0][N-1:0] w_words;
    logic [N-1:0]       w_mux0;
    logic [N-1:0]       w_mux1;
    logic               w_wr_live;
    logic               w_byp0;
    logic               w_byp1;

    // Storage: async clear, then per-entry write decode so entry 0 has no flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_ena) begin
            for (int i = 1; i < 32; i++) begin
                if (wr_addr == 5'(i)) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    // Present the storage as the 32 mux inputs, with word 0 tied to zero.
    always_comb begin
        w_words[0] = '0;
        for (int i = 1; i < 32; i++) begin
            w_words[i] = r_regs[i];
        end
    end

    mux32 #(.N(N)) u_mux_rd0 (
        .i_in  (w_words),
        .i_sel (rd_addr0),
        .o_out (w_mux0)
    );

    mux32 #(.N(N)) u_mux_rd1 (
        .i_in  (w_words),
        .i_sel (rd_addr1),
        .o_out (w_mux1)
    );

    // Bypass is gated by rst so every read stays 0 while reset is held.
    assign w_wr_live = rst & wr_ena & (wr_addr != 5'd0);
    assign w_byp0    = BYPASS & w_wr_live & (rd_addr0 == wr_addr);
    assign w_byp1    = BYPASS & w_wr_live & (rd_addr1 == wr_addr);

    // Read port 0: x0 rule first, then bypass, then stored word.
    always_comb begin
        if (rd_addr0 == 5'd0) begin
            rd_data0 = '0;
        end else if (w_byp0) begin
            rd_data0 = wr_data;
        end else begin
            rd_data0 = w_mux0;
        end
    end

    // Read port 1: same priority as port 0.
    always_comb begin
        if (rd_addr1 == 5'd0) begin
            rd_data1 = '0;
        end else if (w_byp1) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = w_mux1;
        end
    end

endmodule
